// File: rtl/pipelined_addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Chunk width and parameter sanity are derived here.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit chunk_ok(input int n, input int stages);
        return (stages >= 1) && (stages <= n) && (n % stages == 0);
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand and result valid/ready bundle for pipelined_addsub.
// master drives operands and consumes results; slave is the block.
interface pipelined_addsub_if #(
    parameter int N = 32
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );

endinterface

// File: rtl/pipelined_addsub_chunk.sv
// One registered W-bit slice of the adder; carry-out is registered
// together with the sum so the next slice sees it one edge later.
module addsub_chunk #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    logic [W:0] t;

    assign t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            co  <= 1'b0;
        end else if (en) begin
            sum <= t[W-1:0];
            co  <= t[W];
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// N-bit add/subtract split into STAGES registered chunks, with
// operand skew, result deskew and a stall-on-backpressure pipe.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic rst,
    pipelined_addsub_if.slave io
);

    localparam int W = chunk_w(N, STAGES);

    if (!chunk_ok(N, STAGES)) begin : g_chk
        $error("pipelined_addsub: N must be a multiple of STAGES");
    end

    logic              en;
    op_e               op;
    logic [N-1:0]      bx;
    logic [STAGES:0]   c;
    logic [STAGES-1:0] v;
    logic [N-1:0]      s_w;
    logic              ovf_w;

    // The whole pipe moves together; only a held result blocks it.
    assign en = ~v[STAGES-1] | io.out_ready;

    assign op   = op_e'(io.sub);
    assign bx   = (op == OP_SUB) ? ~io.b : io.b;
    assign c[0] = (op == OP_SUB) ? ~io.cin : io.cin;

    assign io.in_ready  = en;
    assign io.out_valid = v[STAGES-1];
    assign io.s         = s_w;
    assign io.cout      = c[STAGES];
    assign io.ovf       = ovf_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (en) begin
            v[0] <= io.in_valid;
            for (int i = 1; i < STAGES; i++) begin
                v[i] <= v[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int D = STAGES - 1 - k;

        logic [W-1:0] xk;
        logic [W-1:0] yk;
        logic [W-1:0] sk;

        if (k == 0) begin : g_in
            assign xk = io.a[k*W +: W];
            assign yk = bx[k*W +: W];
        end else begin : g_skew
            logic [W-1:0] xr [k];
            logic [W-1:0] yr [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        xr[i] <= '0;
                        yr[i] <= '0;
                    end
                end else if (en) begin
                    xr[0] <= io.a[k*W +: W];
                    yr[0] <= bx[k*W +: W];
                    for (int i = 1; i < k; i++) begin
                        xr[i] <= xr[i-1];
                        yr[i] <= yr[i-1];
                    end
                end
            end

            assign xk = xr[k-1];
            assign yk = yr[k-1];
        end

        addsub_chunk #(
            .W(W)
        ) u_chunk (
            .clk(clk),
            .rst(rst),
            .en(en),
            .x(xk),
            .y(yk),
            .ci(c[k]),
            .sum(sk),
            .co(c[k+1])
        );

        if (D == 0) begin : g_out
            assign s_w[k*W +: W] = sk;
        end else begin : g_deskew
            logic [W-1:0] dr [D];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        dr[i] <= '0;
                    end
                end else if (en) begin
                    dr[0] <= sk;
                    for (int i = 1; i < D; i++) begin
                        dr[i] <= dr[i-1];
                    end
                end
            end

            assign s_w[k*W +: W] = dr[D-1];
        end

        // Operand signs travel with the top chunk and land beside its sum.
        if (k == STAGES - 1) begin : g_ovf
            logic as_q;
            logic bs_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    as_q <= 1'b0;
                    bs_q <= 1'b0;
                end else if (en) begin
                    as_q <= xk[W-1];
                    bs_q <= yk[W-1];
                end
            end

            assign ovf_w = (as_q == bs_q) && (sk[W-1] != as_q);
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub at STAGES 4, 1 and 32 sharing one stimulus
// stream; each instance has its own arithmetic scoreboard.
module tb_pipelined_addsub;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    int n_cmp = 0;
    int n_err = 0;

    res_t q4[$];
    res_t q1[$];
    res_t q32[$];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.N(32)) i4 ();
    pipelined_addsub_if #(.N(32)) i1 ();
    pipelined_addsub_if #(.N(32)) i32 ();

    assign i4.in_valid  = in_valid;
    assign i4.a         = a;
    assign i4.b         = b;
    assign i4.cin       = cin;
    assign i4.sub       = sub;
    assign i4.out_ready = out_ready;

    assign i1.in_valid  = in_valid;
    assign i1.a         = a;
    assign i1.b         = b;
    assign i1.cin       = cin;
    assign i1.sub       = sub;
    assign i1.out_ready = out_ready;

    assign i32.in_valid  = in_valid;
    assign i32.a         = a;
    assign i32.b         = b;
    assign i32.cin       = cin;
    assign i32.sub       = sub;
    assign i32.out_ready = out_ready;

    pipelined_addsub #(.N(32), .STAGES(4)) u4 (
        .clk(clk), .rst(rst), .io(i4)
    );
    pipelined_addsub #(.N(32), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .io(i1)
    );
    pipelined_addsub #(.N(32), .STAGES(32)) u32 (
        .clk(clk), .rst(rst), .io(i32)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic meaning of one beat, using wide integers.
    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mc, input logic ms);
        res_t r;
        longint sa, sb, sr, ci;
        longint unsigned ua, ub, u;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'b0, ma};
        ub = {32'b0, mb};
        ci = longint'(mc);
        if (!ms) begin
            u  = ua + ub + longint'(ci);
            sr = sa + sb + ci;
            r.cout = u[32];
        end else begin
            u  = ua - ub - longint'(ci);
            sr = sa - sb - ci;
            r.cout = (ua >= ub + longint'(ci));
        end
        r.s   = u[31:0];
        r.ovf = (sr > SMAX) || (sr < SMIN);
        return r;
    endfunction

    task automatic sb_step(input int id, input bit acc, input bit emit,
                           input res_t got);
        res_t e;
        int   sz;
        e  = '0;
        sz = (id == 0) ? q4.size() : (id == 1) ? q1.size() : q32.size();
        if (emit) begin
            chk($sformatf("sb%0d_avail", id), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                case (id)
                    0:       e = q4.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q32.pop_front();
                endcase
                chk($sformatf("sb%0d_res", id), 64'(got), 64'(e));
            end
        end
        if (acc) begin
            case (id)
                0:       q4.push_back(model(a, b, cin, sub));
                1:       q1.push_back(model(a, b, cin, sub));
                default: q32.push_back(model(a, b, cin, sub));
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            q1.delete();
            q32.delete();
        end else begin
            sb_step(0, i4.in_valid && i4.in_ready,
                    i4.out_valid && i4.out_ready, {i4.s, i4.cout, i4.ovf});
            sb_step(1, i1.in_valid && i1.in_ready,
                    i1.out_valid && i1.out_ready, {i1.s, i1.cout, i1.ovf});
            sb_step(2, i32.in_valid && i32.in_ready,
                    i32.out_valid && i32.out_ready,
                    {i32.s, i32.cout, i32.ovf});
        end
    end

    task automatic directed(input string tag, input logic [31:0] ta,
                            input logic [31:0] tb_, input logic tc,
                            input logic ts, input logic [31:0] es,
                            input logic ec, input logic eo);
        int lat;
        a = ta;
        b = tb_;
        cin = tc;
        sub = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!i4.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_res"}, 64'({i4.s, i4.cout, i4.ovf}), 64'({es, ec, eo}));
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 80 && (q4.size() + q1.size() + q32.size()) != 0;
             k++) begin
            @(posedge clk);
        end
        #1;
        chk(tag, 64'(q4.size() + q1.size() + q32.size()), 64'd0);
    endtask

    task automatic rand_beat();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_vld4", 64'(i4.out_valid), 64'd0);
        chk("rst_res4", 64'({i4.s, i4.cout, i4.ovf}), 64'd0);
        chk("rst_rdy4", 64'(i4.in_ready), 64'd1);
        chk("rst_vld1", 64'(i1.out_valid), 64'd0);
        chk("rst_vld32", 64'(i32.out_valid), 64'd0);

        directed("add", 32'd283, 32'd50, 1'b0, 1'b0, 32'd333, 1'b0, 1'b0);
        directed("carry", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0,
                 32'd0, 1'b1, 1'b0);
        directed("addovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
                 32'h8000_0000, 1'b0, 1'b1);
        directed("sub57", 32'd5, 32'd7, 1'b0, 1'b1,
                 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub75", 32'd7, 32'd5, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0);
        directed("subovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1,
                 32'h7FFF_FFFF, 1'b1, 1'b1);
        drain("drain_dir");

        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 200; i++) begin
            sub = i[0];
            cin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            chk("thru_rdy", 64'(i4.in_ready), 64'd1);
            @(posedge clk);
            #1;
            if (i >= 3) chk("thru_vld", 64'(i4.out_valid), 64'd1);
            a = a + 32'd1318402;
            b = b + 32'd182553;
        end
        in_valid = 1'b0;
        drain("drain_stream");

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rand_beat();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld", 64'(i4.out_valid), 64'd1);
            chk("bp_rdy", 64'(i4.in_ready), 64'd0);
            if (q4.size() != 0)
                chk("bp_res", 64'({i4.s, i4.cout, i4.ovf}), 64'(q4[0]));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("drain_bp");

        for (int i = 0; i < 300; i++) begin
            rand_beat();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_rand");

        for (int i = 0; i < 3; i++) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_vld4", 64'(i4.out_valid), 64'd0);
        chk("mid_s4", 64'(i4.s), 64'd0);
        chk("mid_vld1", 64'(i1.out_valid), 64'd0);
        chk("mid_s1", 64'(i1.s), 64'd0);
        chk("mid_vld32", 64'(i32.out_valid), 64'd0);
        chk("mid_s32", 64'(i32.s), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("mid_stale",
                64'({i4.out_valid, i1.out_valid, i32.out_valid}), 64'd0);
        end

        for (int i = 0; i < 5; i++) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain("drain_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, fully pipelined N-bit adder/subtractor with valid/ready handshakes on input and output. It is the successor to the fixed 32-bit pipelined sequential adder and generalises it in three ways: configurable width and stage count, a per-transaction add/subtract mode, and backpressure support. It sits in the datapath wherever a wide add must meet timing at one result per clock.

## Interface

Parameters:
- `N`, default 32: operand width; must be divisible by `STAGES`.
- `STAGES`, default 4: number of pipeline stages; 1 ≤ `STAGES` ≤ `N`. Chunk width is `W = N/STAGES`.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `in_valid`, input, 1: the operand beat is valid.
- `in_ready`, output, 1: the block accepts a beat this cycle.
- `a`, input, N: operand A (unsigned or two's complement).
- `b`, input, N: operand B.
- `cin`, input, 1: carry-in (add) or borrow-in (sub).
- `sub`, input, 1: 0 = add, 1 = subtract.
- `out_valid`, output, 1: the result beat is valid.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `s`, output, N: sum or difference.
- `cout`, output, 1: carry-out. In subtract mode, 1 means no borrow.
- `ovf`, output, 1: signed two's-complement overflow.

## Operation

Arithmetic:
- Add: `{cout,s} = a + b + cin`.
- Subtract: `{cout,s} = a + ~b + ~cin`, which equals `a - b - cin` modulo 2^N; `cout = 1` means no borrow.
- `ovf = (a[N-1] == b'[N-1]) && (s[N-1] != a[N-1])`, where `b' = sub ? ~b : b`.

Stage structure:
- Stage k (0..STAGES-1) adds chunk k, i.e. bits `[kW+W-1:kW]` of `a` and `b'`, plus the registered carry from stage k-1.
- Stage 0 uses `cin' = sub ? ~cin : cin`.
- Input skew: the operand chunks and sign bits for stage k are delayed by k registers.
- Output deskew: the result chunk from stage k is delayed by STAGES-1-k registers, so all chunks of one transaction emerge together.
- `ovf` is computed in the last stage from the skewed sign bits.

Valid pipeline and handshake:
- A STAGES-deep valid shift register tracks occupancy.
- Global advance enable: `en = ~out_valid | out_ready`.
- `in_ready = en`.
- All pipeline registers (data, carry, valid) update only when `en` is high.
- A beat is accepted when `in_valid && in_ready`. If `in_valid` is low while `en` is high, a bubble enters the pipeline.

Boundary conditions:
- Stall (`out_valid && !out_ready`): the whole pipe freezes, and `s`, `cout`, `ovf`, `out_valid` hold bit-stable; `in_ready` is 0.
- Full throughput: accept and emit happen in the same cycle with no bubble inserted.
- Bubbles between inputs are preserved and never merged or reordered.
- Mode is per-beat: mixing add and subtract beats back to back is legal.
- Reset mid-operation: every in-flight beat is discarded, and no stale beat is emitted after reset deasserts.
- `STAGES == 1`: no skew registers; a single registered stage.
- `STAGES == N`: 1-bit chunks (ripple-pipelined).

## Timing

- Latency: a beat accepted at edge t appears with `out_valid = 1` after edge t+STAGES-1 (visible in cycle t+STAGES-1+1), with no stalls. That is, STAGES register stages from input to output.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- Reset values after the first edge with `rst = 1`: `out_valid = 0`, `s = 0`, `cout = 0`, `ovf = 0`, all valid bits 0, all carry registers 0. Reset has priority over `en`.
- Combinational paths:
  - `in_ready` depends combinationally on `out_ready` and `out_valid` only.
  - No combinational path exists from `a`, `b`, `cin`, `sub` to any output.
- Critical path: one W-bit add plus the carry mux.

## Structure

- Package `addsub_pkg`:
  - function `chunk_w(N, STAGES)`.
  - typedef `op_e` {`OP_ADD`, `OP_SUB`}.
  - elaboration-time check `N % STAGES == 0`.
- Sub-module `addsub_chunk`, parameter W: registered W-bit adder slice with inputs `clk`, `rst`, `en`, `x`, `y`, `ci` and outputs `sum`, `co`.
- The top level instantiates STAGES slices in a generate loop, plus the skew/deskew register arrays and the valid shift register.

## Test plan

- **Basic add:** N=32, STAGES=4, out_ready=1. Drive a=283, b=50, cin=0, sub=0 → s=333, cout=0, ovf=0, exactly 4 cycles after acceptance.
- **Carry across every chunk:** a=0xFFFFFFFF, b=0, cin=1 → s=0, cout=1, ovf=0. Then a=0x7FFFFFFF, b=1 → s=0x80000000, ovf=1.
- **Subtract:**
  - a=5, b=7, sub=1, cin=0 → s=0xFFFFFFFE, cout=0.
  - a=7, b=5, cin=1 → s=1, cout=1.
  - a=0x80000000, b=1 → s=0x7FFFFFFF, ovf=1.
- **Streaming:** 200 back-to-back beats with a += 1318402 and b += 182553, alternating sub → every result matches the reference model, in order, one per cycle.
- **Backpressure:** hold out_ready=0 for 5 cycles with the pipe full → in_ready=0, and s/out_valid stay stable. Release → the remaining beats drain in order with no loss or duplication.
- **Reset mid-flight:** assert rst for 1 cycle with 3 beats in flight → out_valid=0 and s=0 from the next cycle, and no old beat ever appears. Repeat with STAGES=1 and STAGES=32.
